// File: rtl/sfft_pkg.sv
// Shared types and constants for the SFFT frame-readout path.
// Holds the readout FSM state enum and the default frame geometry.
package sfft_pkg;

    localparam int NFFT               = 512;
    localparam int nFFT               = 9;
    localparam int TIME_COUNTER_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DRAIN,
        PEND
    } readout_state_t;

endpackage

// File: rtl/sfft_readout_ctrl_if.sv
// Pipeline-side and host-side signal bundle of the readout controller.
// master: controller view (drives pipe_addr, pipe_read_busy, host_data,
// frame_id, frame_ready, overrun_cnt). slave: pipeline/host view.
interface sfft_readout_ctrl_if
    import sfft_pkg::*;
#(
    parameter int AW     = nFFT,
    parameter int DATA_W = 32,
    parameter int TIME_W = TIME_COUNTER_WIDTH
);

    logic              pipe_valid;
    logic [AW-1:0]     pipe_addr;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_read_busy;
    logic              host_lock;
    logic [AW-1:0]     host_addr;
    logic [DATA_W-1:0] host_data;
    logic [TIME_W-1:0] frame_id;
    logic              frame_ready;
    logic [15:0]       overrun_cnt;

    modport master (
        input  pipe_valid, pipe_data, host_lock, host_addr,
        output pipe_addr, pipe_read_busy, host_data,
        output frame_id, frame_ready, overrun_cnt
    );

    modport slave (
        output pipe_valid, pipe_data, host_lock, host_addr,
        input  pipe_addr, pipe_read_busy, host_data,
        input  frame_id, frame_ready, overrun_cnt
    );

endinterface

// File: rtl/sfft_pingpong_ram.sv
// Two-bank frame buffer: write port into the back bank (~bank_sel),
// registered read port from the front bank (bank_sel).
// Ports: clk, reset (async low, clears read register only), bank_sel,
// we/wr_addr/wr_data (back bank), rd_addr/rd_data (front bank).
module sfft_pingpong_ram #(
    parameter int  N_POINTS = 512,
    parameter int  DATA_W   = 32,
    localparam int AW       = $clog2(N_POINTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bank_sel,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2*N_POINTS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{~bank_sel, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{bank_sel, rd_addr}];
        end
    end

endmodule

// File: rtl/sfft_readout_ctrl.sv
// Copies each completed SFFT frame into the back bank and swaps banks
// only while the host is not reading; tags frames and counts drops.
// Ports: clk, reset (async low), bus (sfft_readout_ctrl_if.master).
// Build option: SFFT_READOUT_OVERRUN_CNT_EN enables the drop counter.
module sfft_readout_ctrl
    import sfft_pkg::*;
#(
    parameter int N_POINTS = NFFT,
    parameter int DATA_W   = 32,
    parameter int TIME_W   = TIME_COUNTER_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    sfft_readout_ctrl_if.master bus
);

    localparam int            AW   = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

    readout_state_t    state, state_nx;
    logic [AW-1:0]     addr, addr_nx;
    logic [AW-1:0]     wr_addr;
    logic [TIME_W-1:0] seq_cnt, cap_id, frame_id_q;
    logic              pv_q, rise;
    logic              hl_q, lock_rise_q;
    logic              bank_sel, swap, we;
    logic              frame_ready_q;
    logic [DATA_W-1:0] rd_data;

    assign rise = bus.pipe_valid & ~pv_q;

    // addr runs one ahead of the RAM data; in DRAIN it has wrapped
    // to 0, so addr-1 lands on the last word.
    assign wr_addr = addr - 1'b1;

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        swap     = 1'b0;
        we       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = COPY;
                    addr_nx  = '0;
                end
            end
            COPY: begin
                addr_nx = addr + 1'b1;
                we      = (addr != '0);
                if (addr == LAST) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                we = 1'b1;
                if (!bus.host_lock) begin
                    swap     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = PEND;
                end
            end
            PEND: begin
                if (!bus.host_lock) begin
                    swap     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            addr          <= '0;
            pv_q          <= 1'b0;
            hl_q          <= 1'b0;
            lock_rise_q   <= 1'b0;
            seq_cnt       <= '0;
            cap_id        <= '0;
            bank_sel      <= 1'b0;
            frame_id_q    <= '0;
            frame_ready_q <= 1'b0;
        end else begin
            state       <= state_nx;
            addr        <= addr_nx;
            pv_q        <= bus.pipe_valid;
            hl_q        <= bus.host_lock;
            lock_rise_q <= bus.host_lock & ~hl_q;
            if (rise) begin
                seq_cnt <= seq_cnt + 1'b1;
            end
            if (state == IDLE && rise) begin
                cap_id <= seq_cnt + 1'b1;
            end
            if (swap) begin
                bank_sel   <= ~bank_sel;
                frame_id_q <= cap_id;
            end
            // a swap wins over a lock rise seen on the same edge
            if (swap) begin
                frame_ready_q <= 1'b1;
            end else if (lock_rise_q) begin
                frame_ready_q <= 1'b0;
            end
        end
    end

`ifdef SFFT_READOUT_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_cnt <= '0;
        end else if (rise && state != IDLE && ovr_cnt != 16'hFFFF) begin
            ovr_cnt <= ovr_cnt + 1'b1;
        end
    end

    assign bus.overrun_cnt = ovr_cnt;
`else
    assign bus.overrun_cnt = '0;
`endif

    sfft_pingpong_ram #(
        .N_POINTS (N_POINTS),
        .DATA_W   (DATA_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .bank_sel (bank_sel),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (bus.pipe_data),
        .rd_addr  (bus.host_addr),
        .rd_data  (rd_data)
    );

    assign bus.pipe_addr      = addr;
    assign bus.pipe_read_busy = (state == COPY) || (state == DRAIN);
    assign bus.host_data      = rd_data;
    assign bus.frame_id       = frame_id_q;
    assign bus.frame_ready    = frame_ready_q;

endmodule
